ram32_fifo_ctrl: RTL and testbench

Synchronous first-word-fall-through FIFO controller for one externally instantiated 32 x 16 quad/octal-port distributed RAM, used as 32-deep x 14-bit storage. The controller owns the write pointer (RAM port H address) and the read pointer (RAM ports A..G addresses). It adds an output holding register, occupancy flags and sticky error flags. It sits between a streaming producer and consumer in the same clock domain and replaces hand-written pointer logic around the RAM.

---
 rtl/ram32_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_ram32_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32_fifo_ctrl.sv
// FWFT FIFO controller around an external 32x14 async-read distributed RAM.
// Latency: an accepted write into an empty FIFO is presented on RD_DATA two edges later; pops refill every cycle.
// Backpressure: FULL/AFULL come from the registered LEVEL; writes while FULL are dropped and flagged in OVF.
module ram32_fifo_ctrl #(
  parameter int unsigned AFULL_THR  = 28,
  parameter int unsigned AEMPTY_THR = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic        WR_EN,
  input  logic [13:0] WR_DATA,
  output logic        FULL,
  output logic        AFULL,
  input  logic        RD_EN,
  output logic [13:0] RD_DATA,
  output logic        VALID,
  output logic        EMPTY,
  output logic        AEMPTY,
  output logic [5:0]  LEVEL,
  output logic        OVF,
  output logic        UDF,
  output logic        RAM_WE,
  output logic [4:0]  RAM_WADDR,
  output logic [13:0] RAM_DI,
  output logic [4:0]  RAM_RADDR,
  input  logic [13:0] RAM_DO
);

  localparam logic [5:0] AFULL_LVL  = 6'(AFULL_THR);
  localparam logic [5:0] AEMPTY_LVL = 6'(AEMPTY_THR);
  localparam logic [5:0] DEPTH      = 6'd32;

  logic [4:0]  wptr;
  logic [4:0]  rptr;
  logic [5:0]  rcnt;      // words sitting in RAM, not yet in the output register
  logic [5:0]  level_q;   // words in RAM plus the output register
  logic        valid_q;
  logic [13:0] dout_q;
  logic        ovf_q;
  logic        udf_q;

  logic        full_q;
  logic        wr_acc;
  logic        rd_acc;
  logic        load;
  logic [5:0]  rcnt_nxt;
  logic [5:0]  level_nxt;

  // Flags decode the LEVEL register only, so no request input reaches them combinationally.
  assign full_q = (level_q == DEPTH);
  assign FULL   = full_q;
  assign AFULL  = (level_q >= AFULL_LVL);
  assign AEMPTY = (level_q <= AEMPTY_LVL);
  assign EMPTY  = ~valid_q;
  assign VALID  = valid_q;
  assign LEVEL  = level_q;
  assign RD_DATA = dout_q;
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

  // RAM write is suppressed during flush and while reset is held so the array is never disturbed.
  assign wr_acc    = WR_EN & ~full_q & ~CLR & ~RST;
  assign rd_acc    = RD_EN & valid_q;
  assign load      = (rcnt != 6'd0) & (~valid_q | rd_acc);
  assign RAM_WE    = wr_acc;
  assign RAM_WADDR = wptr;
  assign RAM_DI    = WR_DATA;
  assign RAM_RADDR = rptr;

  // Next occupancy counts: RAM backlog tracks writes vs. loads, LEVEL tracks writes vs. pops.
  always_comb begin
    rcnt_nxt  = rcnt + {5'd0, wr_acc} - {5'd0, load};
    level_nxt = level_q + {5'd0, wr_acc} - {5'd0, rd_acc};
  end

  // Pointer, occupancy, output register and sticky error state; CLR beats any request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      rcnt    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (CLR) begin
      wptr    <= '0;
      rptr    <= '0;
      rcnt    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 5'd1;
      end
      if (load) begin
        dout_q  <= RAM_DO;
        rptr    <= rptr + 5'd1;
        valid_q <= 1'b1;
      end else if (rd_acc) begin
        valid_q <= 1'b0;
      end
      rcnt    <= rcnt_nxt;
      level_q <= level_nxt;
      if (WR_EN & full_q) begin
        ovf_q <= 1'b1;
      end
      if (RD_EN & ~valid_q) begin
        udf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram32_fifo_ctrl.sv
// Bench for ram32_fifo_ctrl with a behavioural RAM and a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Directed table, corner sequences, then randomized traffic.
module tb_ram32_fifo_ctrl;

  logic        CLK;
  logic        RST;
  logic        CLR;
  logic        WR_EN;
  logic [13:0] WR_DATA;
  logic        FULL;
  logic        AFULL;
  logic        RD_EN;
  logic [13:0] RD_DATA;
  logic        VALID;
  logic        EMPTY;
  logic        AEMPTY;
  logic [5:0]  LEVEL;
  logic        OVF;
  logic        UDF;
  logic        RAM_WE;
  logic [4:0]  RAM_WADDR;
  logic [13:0] RAM_DI;
  logic [4:0]  RAM_RADDR;
  logic [13:0] RAM_DO;

  ram32_fifo_ctrl #(.AFULL_THR(28), .AEMPTY_THR(4)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .AFULL(AFULL), .RD_EN(RD_EN), .RD_DATA(RD_DATA),
    .VALID(VALID), .EMPTY(EMPTY), .AEMPTY(AEMPTY), .LEVEL(LEVEL),
    .OVF(OVF), .UDF(UDF), .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR),
    .RAM_DI(RAM_DI), .RAM_RADDR(RAM_RADDR), .RAM_DO(RAM_DO)
  );

  // External distributed RAM: synchronous write, asynchronous read.
  logic [13:0] mem [32];
  always @(posedge CLK) if (RAM_WE) mem[RAM_WADDR] <= RAM_DI;
  assign RAM_DO = mem[RAM_RADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of words stamped with the edge that wrote them.
  // The head becomes visible at the first edge after its own write where nothing else is shown.
  typedef struct { logic [13:0] d; int t; } ent_t;
  ent_t        mq[$];
  int          edge_n = 0;
  bit          m_shown = 0;
  logic [13:0] m_data = '0;
  bit          m_ovf = 0;
  bit          m_udf = 0;

  task automatic model_reset();
    mq.delete();
    m_shown = 0; m_data = '0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [13:0] wd, input logic rd, input logic clr);
    bit full;
    edge_n++;
    if (clr) begin
      model_reset();
      return;
    end
    full = (mq.size() == 32);
    if (wr && full) m_ovf = 1;
    if (rd && !m_shown) m_udf = 1;
    if (rd && m_shown) begin
      void'(mq.pop_front());
      m_shown = 0;
    end
    if (!m_shown && mq.size() > 0 && mq[0].t < edge_n) begin
      m_shown = 1;
      m_data  = mq[0].d;
    end
    if (wr && !full) mq.push_back('{d: wd, t: edge_n});
  endtask

  task automatic compare_model();
    int sz;
    sz = mq.size();
    check("m_valid",  VALID,  m_shown);
    check("m_empty",  EMPTY,  !m_shown);
    check("m_level",  LEVEL,  sz);
    check("m_full",   FULL,   sz == 32);
    check("m_afull",  AFULL,  sz >= 28);
    check("m_aempty", AEMPTY, sz <= 4);
    check("m_ovf",    OVF,    m_ovf);
    check("m_udf",    UDF,    m_udf);
    if (m_shown) check("m_rd_data", RD_DATA, m_data);
  endtask

  // One clock cycle: drive on the falling edge, check RAM_WE before the rising edge, compare after it.
  task automatic step(input logic wr, input logic [13:0] wd, input logic rd, input logic clr,
                      output logic we_seen);
    @(negedge CLK);
    WR_EN = wr; WR_DATA = wd; RD_EN = rd; CLR = clr;
    #1;
    we_seen = RAM_WE;
    check("ram_we", RAM_WE, (wr && !clr && mq.size() < 32));
    model_edge(wr, wd, rd, clr);
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] wd;
    logic        rd;
    logic        clr;
    logic        e_we;
    logic        e_valid;
    logic [13:0] e_data;
    logic [5:0]  e_level;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t tbl[12];
  logic we;
  int   nexp;
  int   pw;
  int   pr;

  initial begin
    // wr   wd       rd  clr  we  valid data     level ovf udf
    tbl[0]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 6'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 6'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 14'h2A5C, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 6'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 14'h2A5C, 6'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 14'h0111, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0000, 6'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0111, 6'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 14'h0222, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0111, 6'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 14'h0333, 1'b1, 1'b0, 1'b1, 1'b1, 14'h0222, 6'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0333, 6'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 6'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 6'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 14'h3FFF, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 6'd0, 1'b0, 1'b0};

    RST = 1'b1; CLR = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; WR_DATA = '0;

    // Reset state, sampled before any clock edge.
    #2;
    check("rst_level",  LEVEL,   0);
    check("rst_valid",  VALID,   0);
    check("rst_empty",  EMPTY,   1);
    check("rst_aempty", AEMPTY,  1);
    check("rst_full",   FULL,    0);
    check("rst_afull",  AFULL,   0);
    check("rst_ovf",    OVF,     0);
    check("rst_udf",    UDF,     0);
    check("rst_we",     RAM_WE,  0);
    check("rst_data",   RD_DATA, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Directed vectors: underflow, flush, single word latency, write+pop at rcnt=0, back-to-back pops.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr, we);
      check($sformatf("tbl%0d_we", i),     we,     tbl[i].e_we);
      check($sformatf("tbl%0d_valid", i),  VALID,  tbl[i].e_valid);
      check($sformatf("tbl%0d_empty", i),  EMPTY,  !tbl[i].e_valid);
      check($sformatf("tbl%0d_level", i),  LEVEL,  tbl[i].e_level);
      check($sformatf("tbl%0d_aempty", i), AEMPTY, tbl[i].e_level <= 6'd4);
      check($sformatf("tbl%0d_ovf", i),    OVF,    tbl[i].e_ovf);
      check($sformatf("tbl%0d_udf", i),    UDF,    tbl[i].e_udf);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_data", i), RD_DATA, tbl[i].e_data);
    end

    // Fill with 0..31, then overfill, then write+pop while full.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 14'(i), 1'b0, 1'b0, we);
      if (i == 26) check("fill27_afull", AFULL, 0);
      if (i == 27) check("fill28_afull", AFULL, 1);
    end
    check("fill_full",  FULL,  1);
    check("fill_afull", AFULL, 1);
    check("fill_level", LEVEL, 32);
    check("fill_head",  RD_DATA, 0);
    step(1'b1, 14'h3FFF, 1'b0, 1'b0, we);
    check("ovfl_we",    we,    0);
    check("ovfl_ovf",   OVF,   1);
    check("ovfl_level", LEVEL, 32);
    step(1'b1, 14'h3FFE, 1'b1, 1'b0, we);
    check("fullrw_we",    we,      0);
    check("fullrw_level", LEVEL,   31);
    check("fullrw_ovf",   OVF,     1);
    check("fullrw_head",  RD_DATA, 1);

    // Wrap-around streaming: prefill 10, then continuous write+pop, then drain; order must be 0..49.
    step(1'b0, 14'h0, 1'b0, 1'b1, we);
    nexp = 0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 10 && VALID) begin
        check("wrap_order", RD_DATA, nexp);
        nexp++;
      end
      step(i < 50, 14'(i), i >= 10, 1'b0, we);
    end
    for (int n = 0; n < 100 && nexp < 50; n++) begin
      if (VALID) begin
        check("wrap_order", RD_DATA, nexp);
        nexp++;
        step(1'b0, 14'h0, 1'b1, 1'b0, we);
      end else begin
        step(1'b0, 14'h0, 1'b0, 1'b0, we);
      end
    end
    check("wrap_count", nexp, 50);
    check("wrap_level", LEVEL, 0);

    // Flush at LEVEL=20 with both sticky flags set and WR_EN high.
    step(1'b0, 14'h0, 1'b1, 1'b0, we);
    check("flush_pre_udf", UDF, 1);
    for (int i = 0; i < 33; i++) step(1'b1, 14'(i + 100), 1'b0, 1'b0, we);
    for (int i = 0; i < 12; i++) step(1'b0, 14'h0, 1'b1, 1'b0, we);
    check("flush_pre_level", LEVEL, 20);
    check("flush_pre_ovf",   OVF,   1);
    step(1'b1, 14'h1234, 1'b0, 1'b1, we);
    check("flush_we",    we,    0);
    check("flush_level", LEVEL, 0);
    check("flush_empty", EMPTY, 1);
    check("flush_ovf",   OVF,   0);
    check("flush_udf",   UDF,   0);

    // Asynchronous reset mid-stream at LEVEL=10 with requests still asserted.
    for (int i = 0; i < 10; i++) step(1'b1, 14'(i + 200), 1'b0, 1'b0, we);
    check("arst_pre_level", LEVEL, 10);
    WR_EN = 1'b1; RD_EN = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    check("arst_level",  LEVEL,  0);
    check("arst_empty",  EMPTY,  1);
    check("arst_aempty", AEMPTY, 1);
    check("arst_valid",  VALID,  0);
    check("arst_we",     RAM_WE, 0);
    model_reset();
    @(negedge CLK);
    WR_EN = 1'b0; RD_EN = 1'b0;
    RST = 1'b0;

    // Randomized traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 30; pr = 80; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 95; pr = 90; end
      endcase
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(99) < pw, 14'($urandom), $urandom_range(99) < pr,
             $urandom_range(199) == 0, we);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
